me_sw_mem: RTL and testbench
============================

# me_sw_mem

Search-window and current-macroblock memory that serves the `me` motion-estimation core. It loads a 48x48 search window and a 16x16 current macroblock from a single raster-order pixel stream and stores them in column-interleaved banks. It then answers the core's `en_ram`/`addr`/`amt` read requests with one row of 16 current pixels and 17 rotated search pixels per cycle. This is the synthesizable replacement for the behavioural RAM model used around `me`.

## Interface
Parameters:
- MACRO_DIM, 16, macroblock edge; number of current-pixel ports.
- SEARCH_DIM, 48, search-window edge; must be a multiple of MACRO_DIM.
- PORT_WIDTH (localparam), MACRO_DIM+1, number of search banks and search ports.
- SEG (localparam), SEARCH_DIM/MACRO_DIM, number of column segments per search bank.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; begins a new load.
- in_valid  in  1  pixel stream valid.
- in_pixel  in  8  pixel stream data.
- in_ready  out  1  pixel accepted when in_valid&in_ready.
- loaded  out  1  high once both images are stored.
- en_ram  in  1  read request.
- addr  in  6  read row address.
- amt  in  6  bank rotation amount.
- pixel_spr_out  out  8 x PORT_WIDTH  rotated search pixels.
- pixel_cpr_out  out  8 x MACRO_DIM  current pixels.
- rd_valid  out  1  read data valid.
- rd_err  out  1  read request had amt >= PORT_WIDTH.

## Operation
**States:** IDLE, LOAD_SW, LOAD_CUR, READY.
- IDLE -> LOAD_SW on load_start.
- LOAD_SW -> LOAD_CUR after SEARCH_DIM² accepted pixels.
- LOAD_CUR -> READY after MACRO_DIM² accepted pixels.
- load_start in any state clears loaded, zeroes all counters and enters LOAD_SW. Stored contents are not cleared.

**Loading:**
- in_ready = 1 in LOAD_SW and LOAD_CUR, 0 otherwise.
- Both images arrive in raster order: row r outer, column c inner.
- Search pixel (r,c) is written to bank c mod PORT_WIDTH at address (c div PORT_WIDTH)*SEARCH_DIM + r.
  - Bank and segment are tracked by incrementing counters, not a divider.
  - Writes with c div PORT_WIDTH >= SEG are dropped (c = 51 cannot occur for SEARCH_DIM = 48).
- Current pixel (r,c) is written to current bank c at address r.

**Reading:** only in READY, when en_ram = 1.
- pixel_cpr_out[l] = cur bank l at addr. If addr >= MACRO_DIM, the value is 0.
- pixel_spr_out[l] = search bank b = (l+amt) mod PORT_WIDTH, at address addr + (b < amt ? SEARCH_DIM : 0).
  - Address arithmetic is done at 8 bits.
  - An address >= SEG*SEARCH_DIM reads 0.
- If amt >= PORT_WIDTH: all spr outputs are 0 and rd_err = 1. cpr outputs are still served.
- en_ram outside READY is ignored: rd_valid stays 0 and outputs hold.

## Timing
- Reset values: state IDLE; in_ready 0; loaded 0; rd_valid 0; rd_err 0; all pixel outputs 0; counters 0.
- Write: the pixel is stored at the clk edge where in_valid&in_ready. There is no backpressure stall inside a state.
- loaded rises in the cycle after the last current pixel is accepted, together with the entry to READY.
- Read latency is 1 cycle.
  - Request sampled at edge N; pixel outputs, rd_valid and rd_err are registered and valid after edge N.
  - rd_valid = 1 for exactly one cycle per request.
  - Back-to-back requests give one result per cycle.
  - Outputs hold their last value when rd_valid = 0.
- load_start and en_ram in the same cycle while in READY:
  - The read is served from the old contents (rd_valid = 1 next cycle).
  - loaded drops next cycle.
- Reset asserted mid-load or mid-read: all outputs go to their reset values immediately. Memory contents are undefined afterwards.

## Test plan
- Load a search window with pixel(r,c) = (r+c) mod 256 and current pixel(r,c) = 16r+c. Then read addr=0, amt=0 -> spr[l] = l for l = 0..16, cpr[l] = l, rd_valid pulses 1 cycle later, loaded = 1.
- Same data, addr=5, amt=3 -> spr[l] = bank (l+3) mod 17. Banks 0..2 read segment 1 (column 17+b), so spr[14] = 5+17 = 22 and spr[0] = 5+3 = 8.
- Back-to-back reads addr = 0..15, amt=1 -> 16 consecutive rd_valid cycles, cpr[0] = 16*addr.
- Read with amt=17 -> rd_err = 1, all spr = 0, cpr still correct. Read with addr=20 -> cpr all 0.
- Drop in_valid randomly during the load -> counters advance only on handshakes, and loaded rises after exactly 2304+256 accepted pixels.
- Assert load_start in READY together with en_ram -> the old data is returned and loaded = 0. Then pulse rst_n low mid-LOAD_SW -> in_ready = 0 and state IDLE immediately.

Source files
------------

// File: rtl/me_sw_mem.sv
// Search-window / current-macroblock memory feeding the motion-estimation core.
// Loads a SEARCH_DIM^2 search window followed by a MACRO_DIM^2 macroblock from
// one raster-order pixel stream into column-interleaved banks, then serves one
// row of current pixels and PORT_WIDTH rotated search pixels per read request.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   load_start           pulse, restarts loading (contents are kept)
//   in_valid/in_pixel    pixel stream, accepted when in_valid & in_ready
//   in_ready             high while loading
//   loaded               high once both images are stored
//   en_ram/addr/amt      read request: row address and bank rotation
//   pixel_spr_out        rotated search pixels (PORT_WIDTH x 8)
//   pixel_cpr_out        current pixels (MACRO_DIM x 8)
//   rd_valid/rd_err      one-cycle read strobe, rotation out of range
module me_sw_mem #(
  parameter int unsigned MACRO_DIM  = 16,
  parameter int unsigned SEARCH_DIM = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       in_valid,
  input  logic [7:0]                 in_pixel,
  output logic                       in_ready,
  output logic                       loaded,
  input  logic                       en_ram,
  input  logic [5:0]                 addr,
  input  logic [5:0]                 amt,
  output logic [MACRO_DIM:0][7:0]    pixel_spr_out,
  output logic [MACRO_DIM-1:0][7:0]  pixel_cpr_out,
  output logic                       rd_valid,
  output logic                       rd_err
);

  localparam int unsigned PORT_WIDTH = MACRO_DIM + 1;
  localparam int unsigned SEG        = SEARCH_DIM / MACRO_DIM;
  localparam int unsigned SW_DEPTH   = SEG * SEARCH_DIM;
  localparam int unsigned SW_AW      = $clog2(SW_DEPTH);
  localparam int unsigned CNT_W      = $clog2(SEARCH_DIM);
  localparam int unsigned BANK_W     = $clog2(PORT_WIDTH);
  localparam int unsigned SEG_W      = $clog2(SEG + 1);
  localparam int unsigned CUR_AW     = $clog2(MACRO_DIM);

  typedef enum logic [1:0] {IDLE, LOAD_SW, LOAD_CUR, READY} state_t;

  state_t state, state_nxt;
  logic   in_ready_nxt, loaded_nxt;

  logic [CNT_W-1:0]  row, col;
  logic [BANK_W-1:0] bank;
  logic [SEG_W-1:0]  seg;

  logic [7:0] sw_mem  [PORT_WIDTH][SW_DEPTH];
  logic [7:0] cur_mem [MACRO_DIM][MACRO_DIM];

  logic              accept, sw_last, cur_last, rd_fire;
  logic [SW_AW-1:0]  sw_waddr;

  logic [MACRO_DIM:0][7:0]   spr_nxt;
  logic [MACRO_DIM-1:0][7:0] cpr_nxt;
  logic                      err_nxt;

  assign accept   = in_valid & in_ready;
  assign sw_last  = (row == CNT_W'(SEARCH_DIM - 1)) && (col == CNT_W'(SEARCH_DIM - 1));
  assign cur_last = (row == CNT_W'(MACRO_DIM - 1)) && (col == CNT_W'(MACRO_DIM - 1));
  assign sw_waddr = SW_AW'(seg * SEARCH_DIM) + SW_AW'(row);
  assign rd_fire  = (state == READY) && en_ram;

  // State register, with in_ready/loaded registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= in_ready_nxt;
      loaded   <= loaded_nxt;
    end
  end

  // Next-state logic; load_start restarts from any state
  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD_SW;
    end else begin
      case (state)
        LOAD_SW:  if (accept && sw_last)  state_nxt = LOAD_CUR;
        LOAD_CUR: if (accept && cur_last) state_nxt = READY;
        default:  ;
      endcase
    end
  end

  // Output decode from the upcoming state so the flops track the state register
  always_comb begin
    in_ready_nxt = (state_nxt == LOAD_SW) || (state_nxt == LOAD_CUR);
    loaded_nxt   = (state_nxt == READY);
  end

  // Raster counters; bank/seg track column mod/div PORT_WIDTH without a divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      bank <= '0;
      seg  <= '0;
    end else if (load_start) begin
      row  <= '0;
      col  <= '0;
      bank <= '0;
      seg  <= '0;
    end else if (accept) begin
      if (state == LOAD_SW) begin
        if (col == CNT_W'(SEARCH_DIM - 1)) begin
          col  <= '0;
          bank <= '0;
          seg  <= '0;
          row  <= (row == CNT_W'(SEARCH_DIM - 1)) ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
          if (bank == BANK_W'(PORT_WIDTH - 1)) begin
            bank <= '0;
            seg  <= seg + SEG_W'(1);
          end else begin
            bank <= bank + BANK_W'(1);
          end
        end
      end else begin
        if (col == CNT_W'(MACRO_DIM - 1)) begin
          col <= '0;
          row <= (row == CNT_W'(MACRO_DIM - 1)) ? '0 : row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
      end
    end
  end

  // Pixel storage; contents survive reset and load_start
  always_ff @(posedge clk) begin
    if (!load_start && accept && (state == LOAD_SW) && (seg < SEG_W'(SEG)))
      sw_mem[bank][sw_waddr] <= in_pixel;
    if (!load_start && accept && (state == LOAD_CUR))
      cur_mem[col[CUR_AW-1:0]][row[CUR_AW-1:0]] <= in_pixel;
  end

  // Read data: port l sees bank (l+amt) mod PORT_WIDTH; wrapped banks read the next segment
  always_comb begin
    logic [6:0] sum;
    logic       wrap;
    logic [BANK_W-1:0] bank_rd;
    logic [7:0] ra;
    spr_nxt = '0;
    cpr_nxt = '0;
    sum     = '0;
    wrap    = 1'b0;
    bank_rd = '0;
    ra      = '0;
    err_nxt = (amt >= 6'(PORT_WIDTH));
    for (int l = 0; l < PORT_WIDTH; l++) begin
      sum     = 7'(l) + 7'(amt);
      wrap    = (sum >= 7'(PORT_WIDTH));
      bank_rd = wrap ? BANK_W'(sum - 7'(PORT_WIDTH)) : BANK_W'(sum);
      ra      = 8'(addr) + (wrap ? 8'(SEARCH_DIM) : 8'd0);
      if (!err_nxt && (ra < 8'(SW_DEPTH)))
        spr_nxt[BANK_W'(l)] = sw_mem[bank_rd][SW_AW'(ra)];
    end
    if (addr < 6'(MACRO_DIM)) begin
      for (int l = 0; l < MACRO_DIM; l++)
        cpr_nxt[CUR_AW'(l)] = cur_mem[CUR_AW'(l)][addr[CUR_AW-1:0]];
    end
  end

  // Read output registers; hold between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_spr_out <= '0;
      pixel_cpr_out <= '0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        pixel_spr_out <= spr_nxt;
        pixel_cpr_out <= cpr_nxt;
        rd_err        <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_me_sw_mem.sv
// Self-checking bench for me_sw_mem: loads images with random stream gaps and
// checks reads against an image-coordinate reference model.
module tb_me_sw_mem;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_pixel = '0;
  logic             in_ready, loaded;
  logic             en_ram = 1'b0;
  logic [5:0]       addr = '0, amt = '0;
  logic [16:0][7:0] spr;
  logic [15:0][7:0] cpr;
  logic             rd_valid, rd_err;

  me_sw_mem dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .loaded(loaded), .en_ram(en_ram),
    .addr(addr), .amt(amt), .pixel_spr_out(spr), .pixel_cpr_out(cpr),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sw_img  [48][48];
  logic [7:0]   cur_img [16][16];
  logic [135:0] last_spr = '0;
  logic [135:0] last_cpr = '0;
  logic         last_err = 1'b0;
  bit           pend = 1'b0;
  int           p_a, p_m;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Search port l reads column seg*17+b, row r of the window, where the
  // effective address addr (+48 for wrapped banks) splits into seg*48+r.
  function automatic logic [135:0] exp_spr(input int a, input int m);
    logic [135:0] v = '0;
    if (m >= 17) return v;
    for (int l = 0; l < 17; l++) begin
      int b, ea, s, r, c;
      b  = (l + m) % 17;
      ea = a + ((b < m) ? 48 : 0);
      if (ea < 144) begin
        s = ea / 48;
        r = ea % 48;
        c = s * 17 + b;
        if (c < 48) v[l*8 +: 8] = sw_img[r][c];
      end
    end
    return v;
  endfunction

  function automatic logic [135:0] exp_cpr(input int a);
    logic [135:0] v = '0;
    if (a < 16)
      for (int l = 0; l < 16; l++) v[l*8 +: 8] = cur_img[a][l];
    return v;
  endfunction

  // Streams both images with random in_valid gaps; counts only handshakes
  task automatic load_all();
    logic [7:0] stream[$];
    int k, cyc;
    bit hs;
    stream = {};
    for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) stream.push_back(sw_img[r][c]);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) stream.push_back(cur_img[r][c]);
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    chk("in_ready_load", in_ready, 1);
    k = 0; cyc = 0;
    while (k < stream.size() && cyc < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pixel = stream[k];
      if (k == stream.size() - 1 && in_valid) chk("loaded_before_last", loaded, 0);
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) k++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", k, stream.size());
    chk("loaded_after_last", loaded, 1);
    chk("in_ready_done", in_ready, 0);
  endtask

  // Checks the previous cycle's read result (or hold), then drives the next request
  task automatic rd_step(input bit v, input int a, input int m);
    @(negedge clk);
    if (pend) begin
      last_spr = exp_spr(p_a, p_m);
      last_cpr = exp_cpr(p_a);
      last_err = (p_m >= 17);
      chk($sformatf("rd_valid a=%0d m=%0d", p_a, p_m), rd_valid, 1);
    end else begin
      chk("rd_valid_idle", rd_valid, 0);
    end
    chk($sformatf("spr a=%0d m=%0d", p_a, p_m), spr, last_spr);
    chk($sformatf("cpr a=%0d", p_a), cpr, last_cpr);
    chk($sformatf("rd_err m=%0d", p_m), rd_err, last_err);
    en_ram = v; addr = 6'(a); amt = 6'(m);
    pend = v; p_a = a; p_m = m;
  endtask

  initial begin
    for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) sw_img[r][c] = 8'(r + c);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_img[r][c] = 8'(16 * r + c);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_spr", spr, 0);
    chk("rst_cpr", cpr, 0);
    rst_n = 1'b1;

    // IDLE ignores the stream and read requests
    in_valid = 1'b1; en_ram = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_rd_valid", rd_valid, 0);
    in_valid = 1'b0; en_ram = 1'b0;

    load_all();

    rd_step(1, 0, 0);
    rd_step(1, 5, 3);
    rd_step(0, 0, 0);
    chk("spr14_a5_m3", spr[14], 22);
    chk("spr0_a5_m3", spr[0], 8);
    for (int a = 0; a < 16; a++) rd_step(1, a, 1);
    rd_step(1, 0, 17);
    rd_step(1, 20, 2);
    rd_step(1, 50, 0);
    rd_step(1, 63, 18);
    rd_step(0, 0, 0);
    rd_step(0, 0, 0);
    for (int i = 0; i < 20; i++)
      rd_step($urandom_range(0, 4) != 0, $urandom_range(0, 47), $urandom_range(0, 18));
    rd_step(0, 0, 0);
    chk("loaded_hold", loaded, 1);

    // Second load with random content; outputs must hold through it
    for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) sw_img[r][c] = 8'($urandom);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_img[r][c] = 8'($urandom);
    load_all();
    rd_step(0, 0, 0);
    for (int i = 0; i < 20; i++)
      rd_step(1, $urandom_range(0, 47), $urandom_range(0, 18));
    rd_step(0, 0, 0);

    // load_start together with a read in READY: old data returned, loaded drops
    @(negedge clk);
    load_start = 1'b1; en_ram = 1'b1; addr = 6'd7; amt = 6'd4;
    @(negedge clk);
    load_start = 1'b0; en_ram = 1'b0;
    chk("ls_rd_valid", rd_valid, 1);
    chk("ls_spr", spr, exp_spr(7, 4));
    chk("ls_cpr", cpr, exp_cpr(7));
    chk("ls_loaded", loaded, 0);
    chk("ls_in_ready", in_ready, 1);

    // Reset in the middle of LOAD_SW
    in_valid = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_err", rd_err, 0);
    chk("mid_rst_spr", spr, 0);
    chk("mid_rst_cpr", cpr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", in_ready, 0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
